// File: rtl/ufo_pass_scheduler.sv
// ufo_pass_scheduler: launches the bonus UFO after a pseudo-random frame gap, tracks the pass and runs the explosion hold-off.
// Optional feature: define UFO_ALT_DIR_EN to alternate the flight direction on every launch (otherwise direction is 0).
module ufo_pass_scheduler #(
  parameter int unsigned MIN_GAP_FRAMES      = 64,
  parameter int unsigned GAP_RAND_BITS       = 7,
  parameter int unsigned EXPLODE_FRAMES      = 16,
  parameter int unsigned PASS_TIMEOUT_FRAMES = 300,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       shipHit,
  input  logic       shipExited,
  output logic       launch,
  output logic       shipActive,
  output logic       exploding,
  output logic       direction,
  output logic [8:0] bonusScore,
  output logic       scoreValid,
  output logic [7:0] passCount
);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, FLYING, EXPLODE} state_t;

  localparam logic [9:0] TIMEOUT_LD = 10'(PASS_TIMEOUT_FRAMES);
  localparam logic [9:0] EXPL_LD    = 10'(EXPLODE_FRAMES);

  state_t      state, state_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [15:0] lfsr;
  logic        launch_nxt, active_nxt, expl_nxt, sv_nxt;
  logic [8:0]  score_nxt;
  logic [7:0]  pc_nxt;
  logic        frame_end;
  logic [9:0]  gap_val;

  // Gap reload: minimum plus masked LFSR bits, clamped so it never wraps the 10-bit counter.
  function automatic logic [9:0] gap_sat(input logic [15:0] l);
    logic [15:0] mask;
    logic [16:0] sum;
    mask = 16'((32'd1 << GAP_RAND_BITS) - 32'd1);
    sum  = 17'(MIN_GAP_FRAMES) + {1'b0, l & mask};
    if (sum > 17'd1023) gap_sat = 10'd1023;
    else                gap_sat = sum[9:0];
  endfunction

  function automatic logic [8:0] score_lut(input logic [1:0] sel);
    case (sel)
      2'd0:    score_lut = 9'd50;
      2'd1:    score_lut = 9'd100;
      2'd2:    score_lut = 9'd150;
      default: score_lut = 9'd300;
    endcase
  endfunction

  assign gap_val = gap_sat(lfsr);

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    launch_nxt = 1'b0;
    active_nxt = shipActive;
    expl_nxt   = exploding;
    sv_nxt     = 1'b0;
    score_nxt  = bonusScore;
    pc_nxt     = passCount;
    frame_end  = startOfFrame && (cnt == 10'd1);
    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      active_nxt = 1'b0;
      expl_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          active_nxt = 1'b0;
          expl_nxt   = 1'b0;
          state_nxt  = WAIT_GAP;
          cnt_nxt    = gap_val;
        end
        WAIT_GAP: begin
          if (frame_end) begin
            launch_nxt = 1'b1;
            active_nxt = 1'b1;
            pc_nxt     = passCount + 8'd1;
            state_nxt  = FLYING;
            cnt_nxt    = TIMEOUT_LD;
          end else if (startOfFrame) begin
            cnt_nxt = cnt - 10'd1;
          end
        end
        FLYING: begin
          if (shipHit) begin
            active_nxt = 1'b0;
            expl_nxt   = 1'b1;
            sv_nxt     = 1'b1;
            score_nxt  = score_lut(lfsr[1:0]);
            state_nxt  = EXPLODE;
            cnt_nxt    = EXPL_LD;
          end else if (shipExited || frame_end) begin
            active_nxt = 1'b0;
            state_nxt  = WAIT_GAP;
            cnt_nxt    = gap_val;
          end else if (startOfFrame) begin
            cnt_nxt = cnt - 10'd1;
          end
        end
        EXPLODE: begin
          if (frame_end) begin
            expl_nxt  = 1'b0;
            state_nxt = WAIT_GAP;
            cnt_nxt   = gap_val;
          end else if (startOfFrame) begin
            cnt_nxt = cnt - 10'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cnt        <= '0;
      launch     <= 1'b0;
      shipActive <= 1'b0;
      exploding  <= 1'b0;
      scoreValid <= 1'b0;
      bonusScore <= '0;
      passCount  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      launch     <= launch_nxt;
      shipActive <= active_nxt;
      exploding  <= expl_nxt;
      scoreValid <= sv_nxt;
      bonusScore <= score_nxt;
      passCount  <= pc_nxt;
    end
  end

`ifdef UFO_ALT_DIR_EN
  logic dir_nxt;

  // Direction flips together with the launch pulse and holds for the whole pass
  always_comb begin
    dir_nxt = direction;
    if (launch_nxt) dir_nxt = ~direction;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) direction <= 1'b0;
    else         direction <= dir_nxt;
  end
`else
  assign direction = 1'b0;
`endif

endmodule

// File: tb/tb_ufo_pass_scheduler.sv
// Randomized scoreboard bench for ufo_pass_scheduler: a frame-level pass model queues the expected outputs per clock.
module tb_ufo_pass_scheduler;

  localparam int MIN_GAP = 4;
  localparam int RB      = 2;
  localparam int EXF     = 2;
  localparam int TOF     = 8;
  localparam int NCYC    = 14000;

  localparam int M_IDLE = 0;
  localparam int M_GAP  = 1;
  localparam int M_FLY  = 2;
  localparam int M_EXPL = 3;

  typedef struct packed {
    logic       launch;
    logic       shipActive;
    logic       exploding;
    logic       direction;
    logic       scoreValid;
    logic [8:0] bonusScore;
    logic [7:0] passCount;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0, enable = 1'b0, hit = 1'b0, exited = 1'b0;
  logic       launch, shipActive, exploding, direction, scoreValid;
  logic [8:0] bonusScore;
  logic [7:0] passCount;

  int errors = 0;
  int checks = 0;

  exp_t        expq[$];
  int          m_mode, m_frames, m_target;
  logic [15:0] m_lfsr;
  exp_t        m_out;
  int          scores[4] = '{50, 100, 150, 300};

  ufo_pass_scheduler #(
    .MIN_GAP_FRAMES(MIN_GAP), .GAP_RAND_BITS(RB), .EXPLODE_FRAMES(EXF),
    .PASS_TIMEOUT_FRAMES(TOF), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
    .shipHit(hit), .shipExited(exited), .launch(launch), .shipActive(shipActive),
    .exploding(exploding), .direction(direction), .bonusScore(bonusScore),
    .scoreValid(scoreValid), .passCount(passCount)
  );

  always #5 clk = ~clk;

  function automatic int gap_frames(input logic [15:0] l);
    int g;
    g = MIN_GAP + (int'(l) % (1 << RB));
    return (g > 1023) ? 1023 : g;
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_frames = 0;
    m_target = 0;
    m_lfsr   = 16'hACE1;
    m_out    = '0;
  endtask

  task automatic start_gap(input logic [15:0] lf);
    m_mode   = M_GAP;
    m_frames = 0;
    m_target = gap_frames(lf);
  endtask

  // One clock of the pass rules: frames are counted up toward a target rather than down.
  task automatic model_step(input logic s, input logic en, input logic h, input logic x);
    logic [15:0] lf;
    exp_t e;
    lf     = m_lfsr;
    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    e = m_out;
    e.launch = 1'b0;
    e.scoreValid = 1'b0;
    if (!en) begin
      m_mode = M_IDLE;
      e.shipActive = 1'b0;
      e.exploding = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: start_gap(lf);
        M_GAP: if (s) begin
          m_frames++;
          if (m_frames == m_target) begin
            m_mode = M_FLY;
            m_frames = 0;
            e.launch = 1'b1;
            e.shipActive = 1'b1;
            e.passCount = e.passCount + 8'd1;
`ifdef UFO_ALT_DIR_EN
            e.direction = ~e.direction;
`endif
          end
        end
        M_FLY: begin
          if (h) begin
            m_mode = M_EXPL;
            m_frames = 0;
            e.shipActive = 1'b0;
            e.exploding = 1'b1;
            e.scoreValid = 1'b1;
            e.bonusScore = 9'(scores[lf[1:0]]);
          end else begin
            if (s) m_frames++;
            if (x || m_frames == TOF) begin
              e.shipActive = 1'b0;
              start_gap(lf);
            end
          end
        end
        default: if (s) begin
          m_frames++;
          if (m_frames == EXF) begin
            e.exploding = 1'b0;
            start_gap(lf);
          end
        end
      endcase
    end
    m_out = e;
    expq.push_back(e);
  endtask

  // Monitor: all outputs zero while reset is low, otherwise pop one expectation per clock
  always @(posedge clk or negedge resetN) begin
    exp_t a, e;
    #1;
    a = '{launch, shipActive, exploding, direction, scoreValid, bonusScore, passCount};
    if (!resetN) begin
      checks++;
      if (a !== exp_t'('0)) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got %h want 0", $time, a);
      end
    end else if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got launch=%0b act=%0b expl=%0b dir=%0b sv=%0b score=%0d pc=%0d want launch=%0b act=%0b expl=%0b dir=%0b sv=%0b score=%0d pc=%0d",
                 $time, a.launch, a.shipActive, a.exploding, a.direction, a.scoreValid, a.bonusScore, a.passCount,
                 e.launch, e.shipActive, e.exploding, e.direction, e.scoreValid, e.bonusScore, e.passCount);
      end
    end
  end

  initial begin
    int en_hold;
    int pend_rst;
    en_hold  = 0;
    pend_rst = 0;
    model_reset();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      if (c == 12000 || c == 13000) pend_rst++;
      if (pend_rst > 0 && m_mode == M_FLY) begin
        pend_rst--;
        sof = 1'b0; hit = 1'b0; exited = 1'b0;
        #1 resetN = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
      end
      if (en_hold > 0) begin
        enable = 1'b0;
        en_hold--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 299) == 0 || (m_mode == M_EXPL && $urandom_range(0, 5) == 0))
          en_hold = $urandom_range(1, 10);
      end
      sof    = ($urandom_range(0, 2) == 0);
      hit    = ($urandom_range(0, 29) == 0);
      exited = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        hit = 1'b1;
        exited = 1'b1;
      end
      model_step(sof, enable, hit, exited);
      @(negedge clk);
    end
    sof = 1'b0; hit = 1'b0; exited = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
